// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// reset PC default and instruction field positions.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field MSB positions (MIPS-style encoding).
    localparam int OPCODE_MSB  = 31;
    localparam int IMM_MSB     = 15;
    localparam int JTARGET_MSB = 25;

    // Sign-extended 16-bit immediate scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [IMM_MSB:0] imm);
        return {{14{imm[IMM_MSB]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection for the fetch unit.
// Priority: jump_reg > jump > taken beq > taken bne > sequential.
module pc_next
    import fetch_pkg::*;
(
    input  logic [31:0]          i_pc_plus4,
    input  logic [JTARGET_MSB:0] i_instr,
    input  logic [31:0]          i_rs_data,
    input  logic                 i_jump,
    input  logic                 i_jump_reg,
    input  logic                 i_branch,
    input  logic                 i_bne,
    input  logic                 i_alu_zero,
    output logic [31:0]          o_next_pc,
    output logic                 o_misalign
);

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_jr_target;

    assign w_branch_target = i_pc_plus4 + branch_offset(i_instr[IMM_MSB:0]);
    assign w_jump_target   = {i_pc_plus4[31:28], i_instr[JTARGET_MSB:0], 2'b00};
    // The low two bits of a JR target are dropped; misalignment is only flagged.
    assign w_jr_target     = {i_rs_data[31:2], 2'b00};

    // Select the next PC by fixed priority; branch beats bne if both are set.
    always_comb begin
        o_next_pc  = i_pc_plus4;
        o_misalign = 1'b0;
        if (i_jump_reg) begin
            o_next_pc  = w_jr_target;
            o_misalign = |i_rs_data[1:0];
        end else if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (i_branch) begin
            if (i_alu_zero) begin
                o_next_pc = w_branch_target;
            end
        end else if (i_bne && !i_alu_zero) begin
            o_next_pc = w_branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch unit: holds the PC, fetches each
// instruction over a req/ready handshake and computes the next PC.
//
// Handshake: imem_req is high for the whole FETCH state with imem_addr
// (= pc) stable; the transfer completes on the rising edge where
// imem_req and imem_ready are both high, and imem_rdata is captured on
// that edge. imem_ready is don't-care whenever imem_req is low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch,
    input  logic        bne,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic        addr_err,
    output logic [1:0]  dbg_state
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_addr_err;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_imem_req;
    logic        w_instr_valid;
    logic        w_fetch_done;
    logic        w_retire;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_fetch_done = (r_state == ST_FETCH) && imem_ready;
    assign w_retire     = (r_state == ST_EXEC) && !stall;

    pc_next u_pc_next (
        .i_pc_plus4 (w_pc_plus4),
        .i_instr    (r_instr[JTARGET_MSB:0]),
        .i_rs_data  (rs_data),
        .i_jump     (jump),
        .i_jump_reg (jump_reg),
        .i_branch   (branch),
        .i_bne      (bne),
        .i_alu_zero (alu_zero),
        .o_next_pc  (w_next_pc),
        .o_misalign (w_misalign)
    );

    // FSM state register; reset forces IDLE from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and Moore outputs.
    always_comb begin
        w_state_next  = r_state;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_instr_valid = 1'b1;
                if (!stall) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // PC, instruction and address-error registers; a response arriving in
    // the reset cycle is discarded because reset takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            if (w_fetch_done) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc       <= w_next_pc;
                r_addr_err <= w_misalign;
            end
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = w_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign addr_err    = r_addr_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed
// expected values.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        jump;
    logic        jump_reg;
    logic        branch;
    logic        bne;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic        addr_err;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_errors;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .stall       (stall),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .branch      (branch),
        .bne         (bne),
        .alu_zero    (alu_zero),
        .rs_data     (rs_data),
        .addr_err    (addr_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        stall    = 1'b0;
        jump     = 1'b0;
        jump_reg = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        alu_zero = 1'b0;
        rs_data  = 32'd0;
    endtask

    // From FETCH: zero-wait fetch of word, then retire it with the given controls.
    task automatic run_instr(input logic [31:0] word, input logic j, input logic jr,
                             input logic br, input logic bn, input logic z,
                             input logic [31:0] rs);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        check("exec_instr", instr, word);
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        jump     = j;
        jump_reg = jr;
        branch   = br;
        bne      = bn;
        alu_zero = z;
        rs_data  = rs;
        step();
        clear_ctrl();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        clear_ctrl();

        // 1. reset
        step();
        step();
        check("rst_pc",       pc, 32'h0);
        check("rst_instr",    instr, 32'h0);
        check("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check("rst_req",      {31'd0, imem_req}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_state",    {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst = 1'b0;
        check("idle_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("idle_req",   {31'd0, imem_req}, 32'd0);
        step();
        check("fetch_req",  {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, 32'h0);

        // 2. zero-wait sequential
        run_instr(32'h0401_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("seq_pc",    pc, 32'h4);
        check("seq_req",   {31'd0, imem_req}, 32'd1);
        check("seq_addr",  imem_addr, 32'h4);
        check("seq_plus4", pc_plus4, 32'h8);

        // 3. wait states, then stall with jump ignored
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req",   {31'd0, imem_req}, 32'd1);
            check("wait_addr",  imem_addr, 32'h4);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0800_0004;
        step();
        imem_ready = 1'b0;
        stall = 1'b1;
        jump  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_pc",    pc, 32'h4);
            check("stall_instr", instr, 32'h0800_0004);
            check("stall_state", {30'd0, dbg_state}, {30'd0, ST_EXEC});
        end
        stall = 1'b0;
        step();
        clear_ctrl();
        check("jump_after_stall", pc, 32'h10);

        // 4. branches from pc=0x10 with imm=-4 -> target 0x04
        run_instr(32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        check("beq_taken", pc, 32'h04);
        run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("restore_pc1", pc, 32'h10);
        run_instr(32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("beq_not_taken", pc, 32'h14);
        run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("restore_pc2", pc, 32'h10);
        run_instr(32'h1400_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        check("bne_taken", pc, 32'h04);
        run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("restore_pc3", pc, 32'h10);
        run_instr(32'h1000_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        check("beq_bne_both", pc, 32'h04);

        // 5. jumps
        run_instr(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("jump_to_100", pc, 32'h100);
        run_instr(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("jump_from_100", pc, 32'h100);
        check("no_addr_err", {31'd0, addr_err}, 32'd0);
        run_instr(32'h0060_0008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2003);
        check("jr_pc",       pc, 32'h2000);
        check("jr_addr_err", {31'd0, addr_err}, 32'd1);
        step();
        check("jr_addr_err_clr", {31'd0, addr_err}, 32'd0);

        // 6. aligned JR to top of memory, sequential wrap, mid-fetch reset
        run_instr(32'h0060_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        check("jr_top_pc",       pc, 32'hFFFF_FFFC);
        check("jr_top_addr_err", {31'd0, addr_err}, 32'd0);
        check("top_plus4",       pc_plus4, 32'h0);
        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("wrap_pc", pc, 32'h0);
        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("pre_rst_pc", pc, 32'h4);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b0;
        check("midrst_instr", instr, 32'h0);
        check("midrst_pc",    pc, 32'h0);
        check("midrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("recover_req",  {31'd0, imem_req}, 32'd1);
        check("recover_addr", imem_addr, 32'h0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
